decode_sequencer: RTL and testbench
===================================

Name: decode_sequencer

Overview:
- Drives the type-2 decoder from upstream and collects its results downstream.
- Fetches a run of codes from a code program memory and presents each one to the decoder on inp_code with a single-cycle decode_start pulse.
- Waits for the decoder's data_ready pulse, captures out_value and forwards it on a valid/ready result port tagged with its index.
- Guards each decode with a timeout and reports run completion or abort.

Parameters:
- DATA_WIDTH, 32, width of decoder out_value and result_data
- CODE_WIDTH, 8, width of one code word (matches decoder inp_code)
- PROG_ADDR_WIDTH, 4, code program memory address width; max run length 2**PROG_ADDR_WIDTH
- TIMEOUT, 16, max cycles from decode_start pulse to data_ready before abort (>=4)

Ports:
- clock  in  1  system clock, all logic on rising edge
- reset  in  1  asynchronous, active-high reset
- start  in  1  begin a run; sampled only in IDLE
- num_codes  in  PROG_ADDR_WIDTH+1  codes in the run; sampled with start
- prog_addr  out  PROG_ADDR_WIDTH  code program memory read address
- prog_data  in  CODE_WIDTH  code program memory read data, valid 1 cycle after prog_addr
- inp_code  out  CODE_WIDTH  code to decoder
- decode_start  out  1  one-cycle start pulse to decoder
- out_value  in  DATA_WIDTH  decoder result
- data_ready  in  1  decoder result-valid pulse
- result_data  out  DATA_WIDTH  captured result
- result_index  out  PROG_ADDR_WIDTH  program index of the code that produced result_data
- result_valid  out  1  result_data/result_index valid
- result_ready  in  1  downstream accepts result when result_valid && result_ready
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse when a run completes normally
- timeout_err  out  1  sticky; set on timeout, cleared by the next accepted start or reset

Behaviour:
- Reset values:
  - All outputs 0: prog_addr, inp_code, decode_start, result_*, busy, done, timeout_err.
  - State IDLE; internal index and count cleared.
  - Reset mid-run aborts immediately. decode_start drops asynchronously; the decoder recovers on its own.
- IDLE:
  - start=1 with num_codes=0: emit a done pulse next cycle, no decoder activity.
  - start=1 with num_codes>0: latch num_codes, set idx=0, drive prog_addr=0, clear timeout_err, go to FETCH.
  - start is ignored in every other state.
- FETCH (1 cycle): memory read latency. Next state ISSUE.
- ISSUE (1 cycle):
  - Register inp_code <= prog_data and decode_start <= 1.
  - inp_code holds its value until the next ISSUE.
  - decode_start is high for exactly one clock, then forced 0.
  - Clear the timeout counter. Next state WAIT_RDY.
- WAIT_RDY:
  - Increment the timeout counter each cycle.
  - On data_ready=1: capture result_data <= out_value and result_index <= idx, set result_valid=1, go to EMIT.
  - If the counter reaches TIMEOUT without data_ready: set timeout_err=1, go to IDLE with no done pulse and no result.
  - data_ready in any other state is ignored.
- EMIT:
  - Hold result_valid and result_data stable until result_ready=1.
  - On the transfer cycle, drop result_valid next cycle.
  - If idx == num_codes-1: go to DONE.
  - Else: idx <= idx+1, prog_addr <= idx+1, go to FETCH.
  - If result_ready is already high on entry, the transfer takes 1 cycle in EMIT.
- DONE (1 cycle): done=1, then IDLE.
- Run boundaries:
  - num_codes = 2**PROG_ADDR_WIDTH runs the full memory; idx wraps only after the last code, with no extra fetch.
  - num_codes > 2**PROG_ADDR_WIDTH is clamped to 2**PROG_ADDR_WIDTH.
- Throughput: one decode in flight at a time; never a second decode_start before the prior data_ready or timeout.
- busy=1 from the cycle after an accepted start through the DONE cycle. busy=0 in the cycle after a timeout.

Test Plan:
- Single code: program[0]=8'h25, num_codes=1, start; decoder model returns 32'hDEADBEEF -> exactly one decode_start pulse with inp_code=8'h25; one result 32'hDEADBEEF with index 0; one done pulse; busy then 0.
- Run of 16 codes 8'h00..8'h0F with result_ready tied high, model returns code*3 -> 16 results in index order 0..15 with correct values; 16 decode_start pulses, each 1 cycle wide; done once.
- Backpressure: num_codes=3, result_ready low for 5 cycles on result 1 -> result_valid and result_data held stable all 5 cycles; no decode_start issued meanwhile; all 3 results delivered.
- Timeout: the model never asserts data_ready -> timeout_err=1 exactly TIMEOUT cycles after decode_start; no result; no done; IDLE; the next start clears timeout_err.
- num_codes=0 and num_codes=31 (clamped): 0 gives done with zero decode_start pulses; 31 gives exactly 16 decodes.
- Reset asserted in WAIT_RDY of code 2 of 4 -> all outputs 0 immediately; after release, a new start of 4 codes completes normally with indices 0..3.

Source files
------------

// File: rtl/decode_sequencer.sv
// decode_sequencer: walks a code program through the type-2 decoder one code at a time
// and forwards each decoded value on a valid/ready result port tagged with its index.
module decode_sequencer #(
    parameter int DATA_WIDTH      = 32,
    parameter int CODE_WIDTH      = 8,
    parameter int PROG_ADDR_WIDTH = 4,
    parameter int TIMEOUT         = 16
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       start,
    input  logic [PROG_ADDR_WIDTH:0]   num_codes,
    output logic [PROG_ADDR_WIDTH-1:0] prog_addr,
    input  logic [CODE_WIDTH-1:0]      prog_data,
    output logic [CODE_WIDTH-1:0]      inp_code,
    output logic                       decode_start,
    input  logic [DATA_WIDTH-1:0]      out_value,
    input  logic                       data_ready,
    output logic [DATA_WIDTH-1:0]      result_data,
    output logic [PROG_ADDR_WIDTH-1:0] result_index,
    output logic                       result_valid,
    input  logic                       result_ready,
    output logic                       busy,
    output logic                       done,
    output logic                       timeout_err
);
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [PROG_ADDR_WIDTH:0] MAX_CODES = {1'b1, {PROG_ADDR_WIDTH{1'b0}}};

    typedef enum logic [2:0] {IDLE, FETCH, ISSUE, WAIT_RDY, EMIT, FINISH} state_t;

    state_t                     state;
    logic [PROG_ADDR_WIDTH:0]   count;
    logic [PROG_ADDR_WIDTH-1:0] idx;
    logic [TW-1:0]              tcnt;
    logic                       last;

    // idx is one bit narrower than count, so a full-memory run ends on idx == all ones
    assign last = {1'b0, idx} == count - 1'b1;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state        <= IDLE;
            count        <= '0;
            idx          <= '0;
            tcnt         <= '0;
            prog_addr    <= '0;
            inp_code     <= '0;
            decode_start <= 1'b0;
            result_data  <= '0;
            result_index <= '0;
            result_valid <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
            timeout_err  <= 1'b0;
        end else begin
            decode_start <= 1'b0;
            done         <= 1'b0;
            case (state)
                IDLE: if (start) begin
                    timeout_err <= 1'b0;
                    busy        <= 1'b1;
                    if (num_codes == '0) begin
                        done  <= 1'b1;
                        state <= FINISH;
                    end else begin
                        count     <= num_codes > MAX_CODES ? MAX_CODES : num_codes;
                        idx       <= '0;
                        prog_addr <= '0;
                        state     <= FETCH;
                    end
                end
                FETCH: state <= ISSUE;
                ISSUE: begin
                    inp_code     <= prog_data;
                    decode_start <= 1'b1;
                    tcnt         <= '0;
                    state        <= WAIT_RDY;
                end
                WAIT_RDY: if (data_ready) begin
                    result_data  <= out_value;
                    result_index <= idx;
                    result_valid <= 1'b1;
                    state        <= EMIT;
                end else if (tcnt == TW'(TIMEOUT - 1)) begin
                    timeout_err <= 1'b1;
                    busy        <= 1'b0;
                    state       <= IDLE;
                end else begin
                    tcnt <= tcnt + 1'b1;
                end
                EMIT: if (result_ready) begin
                    result_valid <= 1'b0;
                    if (last) begin
                        done  <= 1'b1;
                        state <= FINISH;
                    end else begin
                        idx       <= idx + 1'b1;
                        prog_addr <= idx + 1'b1;
                        state     <= FETCH;
                    end
                end
                FINISH: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_decode_sequencer.sv
// tb_decode_sequencer: randomized bench for decode_sequencer with a transaction-level
// reference model that predicts every output each cycle, plus literal per-scenario checks.
module tb_decode_sequencer;
    localparam int TIMEOUT = 16;

    logic        clock = 1'b0;
    logic        reset;
    logic        start;
    logic [4:0]  num_codes;
    logic [3:0]  prog_addr;
    logic [7:0]  prog_data;
    logic [7:0]  inp_code;
    logic        decode_start;
    logic [31:0] out_value;
    logic        data_ready;
    logic [31:0] result_data;
    logic [3:0]  result_index;
    logic        result_valid;
    logic        result_ready;
    logic        busy;
    logic        done;
    logic        timeout_err;

    decode_sequencer #(
        .DATA_WIDTH(32), .CODE_WIDTH(8), .PROG_ADDR_WIDTH(4), .TIMEOUT(TIMEOUT)
    ) dut (
        .clock(clock), .reset(reset), .start(start), .num_codes(num_codes),
        .prog_addr(prog_addr), .prog_data(prog_data), .inp_code(inp_code),
        .decode_start(decode_start), .out_value(out_value), .data_ready(data_ready),
        .result_data(result_data), .result_index(result_index), .result_valid(result_valid),
        .result_ready(result_ready), .busy(busy), .done(done), .timeout_err(timeout_err)
    );

    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;

    logic [7:0]  mem [16];
    int          dec_mode = 0;
    int          dec_lat = 3;
    logic        fixed_en = 1'b0;
    logic [31:0] fixed_val = '0;
    logic [31:0] salt = '0;
    int          rr_mode = 0;
    int          hold = 0;
    int          ds_cnt = 0;
    int          done_cnt = 0;
    logic [35:0] resq [$];

    logic        exp_ds, exp_rv, exp_done, exp_busy, exp_te;
    logic [7:0]  exp_code;
    logic [31:0] exp_rd;
    logic [3:0]  exp_ri, exp_pa;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 0x%0h, required 0x%0h at %0t", name, act, req, $time);
        end
    endtask

    always @(posedge clock) prog_data <= mem[prog_addr];

    // decoder: dec_mode 0 random latency, 1 never answers, 2 fixed latency
    initial begin
        int lat;
        data_ready = 1'b0;
        out_value  = '0;
        forever begin
            @(negedge clock);
            if (decode_start && !reset && dec_mode != 1) begin
                lat = dec_mode == 2 ? dec_lat : int'($urandom_range(0, 4));
                repeat (lat) @(negedge clock);
                data_ready = 1'b1;
                out_value  = fixed_en ? fixed_val : (32'(inp_code) * 3) ^ salt;
                @(negedge clock);
                data_ready = 1'b0;
                out_value  = $urandom;
            end
        end
    end

    always @(negedge clock) begin
        if (rr_mode == 0) result_ready = 1'b1;
        else if (rr_mode == 1) result_ready = 1'($urandom_range(0, 1));
        else if (result_valid && result_index == 4'd1 && hold < 5) begin
            result_ready = 1'b0;
            hold++;
        end else result_ready = 1'b1;
    end

    always @(posedge clock) if (!reset) begin
        if (decode_start) ds_cnt++;
        if (done) done_cnt++;
        if (result_valid && result_ready) resq.push_back({result_index, result_data});
    end

    task automatic zero_exp();
        exp_ds = 0; exp_rv = 0; exp_done = 0; exp_busy = 0; exp_te = 0;
        exp_code = '0; exp_rd = '0; exp_ri = '0; exp_pa = '0;
    endtask

    task automatic tick(output bit ab);
        @(posedge clock);
        ab = reset;
        if (ab) zero_exp();
    endtask

    // one run as a sequence of transactions: fetch, issue, await result, hand it off
    task automatic model_run(input int n);
        bit ab;
        int k;
        for (int i = 0; i < n; i++) begin
            tick(ab); if (ab) return;
            tick(ab); if (ab) return;
            exp_code = mem[i];
            exp_ds   = 1;
            k = 0;
            forever begin
                tick(ab); if (ab) return;
                exp_ds = 0;
                k++;
                if (data_ready) begin
                    exp_rv = 1; exp_rd = out_value; exp_ri = 4'(i);
                    break;
                end
                if (k == TIMEOUT) begin
                    exp_te = 1; exp_busy = 0;
                    return;
                end
            end
            forever begin
                tick(ab); if (ab) return;
                if (result_ready) break;
            end
            exp_rv = 0;
            if (i < n - 1) exp_pa = 4'(i + 1);
            else exp_done = 1;
        end
        tick(ab); if (ab) return;
        exp_done = 0; exp_busy = 0;
    endtask

    initial begin
        bit ab;
        zero_exp();
        forever begin
            tick(ab);
            if (!ab && start) begin
                exp_te = 0; exp_busy = 1;
                if (num_codes == 0) begin
                    exp_done = 1;
                    tick(ab);
                    if (!ab) begin exp_done = 0; exp_busy = 0; end
                end else begin
                    exp_pa = 0;
                    model_run(num_codes > 16 ? 16 : int'(num_codes));
                end
            end
        end
    end

    always @(negedge clock) begin
        chk("prog_addr",    32'(prog_addr),    reset ? 0 : 32'(exp_pa));
        chk("inp_code",     32'(inp_code),     reset ? 0 : 32'(exp_code));
        chk("decode_start", 32'(decode_start), reset ? 0 : 32'(exp_ds));
        chk("result_data",  result_data,       reset ? 0 : exp_rd);
        chk("result_index", 32'(result_index), reset ? 0 : 32'(exp_ri));
        chk("result_valid", 32'(result_valid), reset ? 0 : 32'(exp_rv));
        chk("busy",         32'(busy),         reset ? 0 : 32'(exp_busy));
        chk("done",         32'(done),         reset ? 0 : 32'(exp_done));
        chk("timeout_err",  32'(timeout_err),  reset ? 0 : 32'(exp_te));
    end

    task automatic clear();
        ds_cnt = 0;
        done_cnt = 0;
        resq.delete();
    endtask

    task automatic run(input int n, input int budget, input bit noise);
        int c = 0;
        @(negedge clock);
        start = 1'b1;
        num_codes = 5'(n);
        @(negedge clock);
        start = 1'b0;
        while (busy && c < budget) begin
            start = noise && $urandom_range(0, 7) == 0;
            num_codes = 5'($urandom);
            @(negedge clock);
            c++;
        end
        start = 1'b0;
        chk("run_finish_busy", 32'(busy), 0);
    endtask

    task automatic check_results(input string name, input int n, input logic [7:0] base, input bit from_mem);
        logic [7:0] code;
        chk({name, "_count"}, resq.size(), n);
        for (int i = 0; i < resq.size() && i < n; i++) begin
            code = from_mem ? mem[i] : base + 8'(i);
            chk({name, "_index"}, 32'(resq[i][35:32]), i);
            chk({name, "_data"}, resq[i][31:0], (32'(code) * 3) ^ salt);
        end
    endtask

    initial begin
        int c;
        reset = 1'b1;
        start = 1'b0;
        num_codes = '0;
        for (int i = 0; i < 16; i++) mem[i] = '0;
        repeat (3) @(negedge clock);
        chk("reset_busy", 32'(busy), 0);
        chk("reset_prog_addr", 32'(prog_addr), 0);
        reset = 1'b0;

        mem[0] = 8'h25;
        fixed_en = 1'b1;
        fixed_val = 32'hDEADBEEF;
        clear();
        run(1, 200, 0);
        chk("single_ds_count", ds_cnt, 1);
        chk("single_done_count", done_cnt, 1);
        chk("single_result_count", resq.size(), 1);
        if (resq.size() > 0) begin
            chk("single_result_data", resq[0][31:0], 32'hDEADBEEF);
            chk("single_result_index", 32'(resq[0][35:32]), 0);
        end
        chk("single_inp_code", 32'(inp_code), 32'h25);
        fixed_en = 1'b0;

        for (int i = 0; i < 16; i++) mem[i] = 8'(i);
        clear();
        run(16, 1000, 0);
        chk("full_ds_count", ds_cnt, 16);
        chk("full_done_count", done_cnt, 1);
        check_results("full", 16, 8'h00, 0);

        for (int i = 0; i < 16; i++) mem[i] = 8'h40 + 8'(i);
        rr_mode = 2;
        hold = 0;
        clear();
        run(3, 300, 0);
        rr_mode = 0;
        chk("bp_stall_cycles", hold, 5);
        chk("bp_ds_count", ds_cnt, 3);
        chk("bp_done_count", done_cnt, 1);
        check_results("bp", 3, 8'h40, 0);

        dec_mode = 1;
        clear();
        @(negedge clock);
        start = 1'b1;
        num_codes = 5'd2;
        @(negedge clock);
        start = 1'b0;
        c = 0;
        while (!decode_start && c < 20) begin @(negedge clock); c++; end
        chk("to_saw_decode_start", 32'(decode_start), 1);
        c = 0;
        while (!timeout_err && c < 100) begin @(negedge clock); c++; end
        chk("to_latency", c, TIMEOUT);
        chk("to_busy", 32'(busy), 0);
        chk("to_ds_count", ds_cnt, 1);
        chk("to_done_count", done_cnt, 0);
        chk("to_result_count", resq.size(), 0);
        dec_mode = 0;
        clear();
        run(1, 200, 0);
        chk("to_cleared", 32'(timeout_err), 0);
        chk("to_next_done", done_cnt, 1);

        clear();
        run(0, 50, 0);
        chk("zero_ds_count", ds_cnt, 0);
        chk("zero_done_count", done_cnt, 1);
        chk("zero_result_count", resq.size(), 0);
        for (int i = 0; i < 16; i++) mem[i] = 8'(i);
        clear();
        run(31, 1000, 0);
        chk("clamp_ds_count", ds_cnt, 16);
        chk("clamp_done_count", done_cnt, 1);
        check_results("clamp", 16, 8'h00, 0);

        for (int i = 0; i < 16; i++) mem[i] = 8'h80 + 8'(i);
        dec_mode = 2;
        dec_lat = 3;
        clear();
        @(negedge clock);
        start = 1'b1;
        num_codes = 5'd4;
        @(negedge clock);
        start = 1'b0;
        c = 0;
        while (ds_cnt < 3 && c < 200) begin @(negedge clock); c++; end
        chk("rst_reached_code2", ds_cnt, 3);
        #2 reset = 1'b1;
        #1;
        chk("rst_busy", 32'(busy), 0);
        chk("rst_prog_addr", 32'(prog_addr), 0);
        chk("rst_inp_code", 32'(inp_code), 0);
        chk("rst_result_valid", 32'(result_valid), 0);
        chk("rst_result_data", result_data, 0);
        repeat (3) @(negedge clock);
        reset = 1'b0;
        repeat (3) @(negedge clock);
        dec_mode = 0;
        clear();
        run(4, 400, 0);
        chk("rst_rerun_done", done_cnt, 1);
        check_results("rst_rerun", 4, 8'h80, 0);

        salt = $urandom;
        for (int r = 0; r < 25; r++) begin
            int n;
            for (int i = 0; i < 16; i++) mem[i] = 8'($urandom);
            n = $urandom_range(0, 20);
            rr_mode = $urandom_range(0, 1);
            dec_mode = $urandom_range(0, 7) == 0 ? 1 : 0;
            clear();
            run(n, 3000, 1);
            if (dec_mode == 1 && n > 0) chk("rand_timeout", 32'(timeout_err), 1);
            else check_results("rand", n > 16 ? 16 : n, 8'h00, 1);
        end
        rr_mode = 0;
        dec_mode = 0;
        repeat (2) @(negedge clock);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
